// File: rtl/param_regfile_pkg.sv
// Shared defaults, sizing helpers and the read-source encoding for the
// parametrised multi-port register file.
package param_regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;

  // Where a read port takes its value from in the current cycle.
  typedef enum logic [1:0] {
    SRC_STORE = 2'd0,
    SRC_WP0   = 2'd1,
    SRC_WP1   = 2'd2,
    SRC_ZERO  = 2'd3
  } rd_src_e;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic int rd_slice(input int port, input int addr_w);
    return port * addr_w;
  endfunction

  // Offset of the readdata field that read port 'port' drives.
  function automatic int wr_slice(input int port, input int data_w);
    return port * data_w;
  endfunction

endpackage

// File: rtl/param_regfile_if.sv
// Write-port / read-port bundle between the pipeline (master) and the
// register file (slave).
interface param_regfile_if
  import param_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
);

  logic                     regwrite0;
  logic [ADDR_W-1:0]        writereg0;
  logic [DATA_W-1:0]        writedata0;
  logic                     regwrite1;
  logic [ADDR_W-1:0]        writereg1;
  logic [DATA_W-1:0]        writedata1;
  logic [NUM_RD*ADDR_W-1:0] readreg;
  logic [NUM_RD*DATA_W-1:0] readdata;

  modport master (
    output regwrite0, writereg0, writedata0,
    output regwrite1, writereg1, writedata1,
    output readreg,
    input  readdata
  );

  modport slave (
    input  regwrite0, writereg0, writedata0,
    input  regwrite1, writereg1, writedata1,
    input  readreg,
    output readdata
  );

endinterface

// File: rtl/param_regfile_reg_wr_decoder.sv
// Address-to-one-hot write decoder; one instance per write port. With DROP_R0
// set, register 0 can never be selected so it stays at its reset value.
module reg_wr_decoder
  import param_regfile_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DROP_R0 = 1
) (
  input  logic                        en_i,
  input  logic [ADDR_W-1:0]           addr_i,
  output logic [depth_of(ADDR_W)-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[addr_i] = 1'b1;
    end
    if (DROP_R0 != 0) begin
      onehot_o[0] = 1'b0;
    end
  end

endmodule

// File: rtl/param_regfile.sv
// DEPTH x DATA_W register file with two write ports (port 1 wins on conflict),
// NUM_RD combinational read ports and same-cycle write-to-read bypass.
module param_regfile
  import param_regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_RD  = NUM_RD_DEF,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic           clk,
  input  logic           reset,
  param_regfile_if.slave rf
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DEPTH-1:0]             dec0;
  logic [DEPTH-1:0]             dec1;
  logic [DEPTH-1:0]             wen;
  logic [DEPTH-1:0][DATA_W-1:0] regs_q;
  logic [DEPTH-1:0][DATA_W-1:0] regs_d;

  reg_wr_decoder #(
    .ADDR_W  (ADDR_W),
    .DROP_R0 (ZERO_R0)
  ) u_dec0 (
    .en_i     (rf.regwrite0),
    .addr_i   (rf.writereg0),
    .onehot_o (dec0)
  );

  reg_wr_decoder #(
    .ADDR_W  (ADDR_W),
    .DROP_R0 (ZERO_R0)
  ) u_dec1 (
    .en_i     (rf.regwrite1),
    .addr_i   (rf.writereg1),
    .onehot_o (dec1)
  );

  assign wen = dec0 | dec1;

  // Port 1 data wins whenever both ports hit the same register.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wen[i]) begin
        regs_d[i] = dec1[i] ? rf.writedata1 : rf.writedata0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    rd_src_e           src;
    logic [DATA_W-1:0] rdata;

    assign raddr = rf.readreg[rd_slice(k, ADDR_W) +: ADDR_W];

    // Bypass priority mirrors the storage rule; reset forces zero so no
    // pre-reset contents or in-flight write data leak out.
    always_comb begin
      src = SRC_STORE;
      if (reset) begin
        src = SRC_ZERO;
      end else if ((ZERO_R0 != 0) && (raddr == '0)) begin
        src = SRC_ZERO;
      end else if ((BYPASS != 0) && rf.regwrite1 && (rf.writereg1 == raddr)) begin
        src = SRC_WP1;
      end else if ((BYPASS != 0) && rf.regwrite0 && (rf.writereg0 == raddr)) begin
        src = SRC_WP0;
      end
    end

    always_comb begin
      rdata = '0;
      case (src)
        SRC_STORE: rdata = regs_q[raddr];
        SRC_WP0:   rdata = rf.writedata0;
        SRC_WP1:   rdata = rf.writedata1;
        default:   rdata = '0;
      endcase
    end

    assign rf.readdata[wr_slice(k, DATA_W) +: DATA_W] = rdata;
  end

endmodule

// File: tb/tb_param_regfile.sv
// Self-checking bench for param_regfile: directed vector table, random traffic
// against a behavioural model, and a full-array reset sweep.
module tb_param_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  typedef struct {
    logic          rst;
    logic          we0;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic          we1;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [DW-1:0] exp0;
    logic [DW-1:0] exp1;
  } vec_t;

  typedef struct {
    string         name;
    int            port;
    logic [DW-1:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic reset;

  vec_t          vecs[$];
  sb_t           sbq[$];
  logic [DW-1:0] mem[32];
  int            checks   = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  param_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) rf_if ();

  param_regfile #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .NUM_RD  (NR),
    .ZERO_R0 (1),
    .BYPASS  (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf_if)
  );

  function automatic vec_t mk(input logic rst, input logic we0, input logic [AW-1:0] wa0,
                              input logic [DW-1:0] wd0, input logic we1, input logic [AW-1:0] wa1,
                              input logic [DW-1:0] wd1, input logic [AW-1:0] ra0,
                              input logic [AW-1:0] ra1, input logic [DW-1:0] exp0,
                              input logic [DW-1:0] exp1);
    vec_t v;
    v.rst = rst; v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
    v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
    v.ra0 = ra0; v.ra1 = ra1; v.exp0 = exp0; v.exp1 = exp1;
    return v;
  endfunction

  // Independent model of what a read port should show this cycle.
  function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] ra, input vec_t v);
    if (v.rst) return '0;
    if (ra == '0) return '0;
    if (v.we1 && (v.wa1 == ra)) return v.wd1;
    if (v.we0 && (v.wa0 == ra)) return v.wd0;
    return mem[ra];
  endfunction

  task automatic modelCommit(input vec_t v);
    if (v.rst) begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
    end else begin
      if (v.we0 && v.wa0 != '0) mem[v.wa0] = v.wd0;
      if (v.we1 && v.wa1 != '0) mem[v.wa1] = v.wd1;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    sb_t e;
    reset            = v.rst;
    rf_if.regwrite0  = v.we0;
    rf_if.writereg0  = v.wa0;
    rf_if.writedata0 = v.wd0;
    rf_if.regwrite1  = v.we1;
    rf_if.writereg1  = v.wa1;
    rf_if.writedata1 = v.wd1;
    rf_if.readreg    = {v.ra1, v.ra0};
    e.name = name; e.port = 0; e.exp = v.exp0;
    sbq.push_back(e);
    e.port = 1; e.exp = v.exp1;
    sbq.push_back(e);
  endtask

  task automatic checkOutput();
    sb_t           e;
    logic [DW-1:0] got;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      got = rf_if.readdata[e.port*DW +: DW];
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("[TB] FAIL %s port%0d got=%h exp=%h", e.name, e.port, got, e.exp);
      end
    end
  endtask

  // Drive at negedge, sample mid-low-phase, commit on the following posedge.
  task automatic runCycle(input vec_t v, input string name);
    @(negedge clk);
    applyStimulus(v, name);
    #2;
    checkOutput();
  endtask

  initial begin
    vec_t v;
    reset            = 1'b1;
    rf_if.regwrite0  = 1'b0;
    rf_if.writereg0  = '0;
    rf_if.writedata0 = '0;
    rf_if.regwrite1  = 1'b0;
    rf_if.writereg1  = '0;
    rf_if.writedata1 = '0;
    rf_if.readreg    = '0;

    //           rst we0 wa0 wd0           we1 wa1 wd1           ra0 ra1 exp0          exp1
    vecs.push_back(mk(1, 1, 10, 32'h55,       0, 0,  0,            10, 0,  0,            0));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            10, 6,  0,            0));
    vecs.push_back(mk(0, 1, 5,  32'hDEADBEEF, 0, 0,  0,            5,  6,  32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            5,  6,  32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 1, 7,  32'h12345678, 0, 0,  0,            5,  7,  32'hDEADBEEF, 32'h12345678));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            7,  7,  32'h12345678, 32'h12345678));
    vecs.push_back(mk(0, 1, 9,  32'h1111,     1, 9,  32'h2222,     9,  5,  32'h2222,     32'hDEADBEEF));
    vecs.push_back(mk(0, 1, 3,  32'hA,        1, 4,  32'hB,        9,  3,  32'h2222,     32'hA));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            3,  4,  32'hA,        32'hB));
    vecs.push_back(mk(0, 1, 0,  32'h1234,     1, 0,  32'hFFFFFFFF, 0,  0,  0,            0));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0,  9,  0,            32'h2222));
    vecs.push_back(mk(0, 1, 12, 32'h77,       1, 13, 32'h88,       12, 13, 32'h77,       32'h88));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            13, 12, 32'h88,       32'h77));
    vecs.push_back(mk(0, 0, 0,  0,            1, 31, 32'h80000001, 31, 31, 32'h80000001, 32'h80000001));
    vecs.push_back(mk(0, 1, 1,  32'h5A5A5A5A, 0, 0,  0,            1,  31, 32'h5A5A5A5A, 32'h80000001));
    vecs.push_back(mk(1, 1, 20, 32'h55,       1, 5,  32'h66,       20, 5,  0,            0));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            20, 5,  0,            0));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            31, 9,  0,            0));

    foreach (vecs[i]) begin
      runCycle(vecs[i], $sformatf("row%0d", i));
    end

    // Random two-port traffic with aliasing reads, checked against the model.
    for (int i = 0; i < 32; i++) mem[i] = '0;
    for (int n = 0; n < 300; n++) begin
      v.rst = 1'b0;
      v.we0 = 1'($urandom_range(0, 1));
      v.wa0 = AW'($urandom_range(0, 7));
      v.wd0 = $urandom;
      v.we1 = 1'($urandom_range(0, 1));
      v.wa1 = AW'($urandom_range(0, 7));
      v.wd1 = $urandom;
      v.ra0 = AW'($urandom_range(0, 7));
      v.ra1 = AW'($urandom_range(0, 7));
      v.exp0 = modelRead(v.ra0, v);
      v.exp1 = modelRead(v.ra1, v);
      runCycle(v, $sformatf("rand%0d", n));
      modelCommit(v);
    end

    // Fill every register, then a single reset cycle must clear the whole array.
    for (int i = 1; i < 32; i++) begin
      v = mk(0, 1, AW'(i), $urandom | 32'h1, 0, 0, 0, AW'(i), 0, 0, 0);
      v.exp0 = modelRead(v.ra0, v);
      v.exp1 = modelRead(v.ra1, v);
      runCycle(v, $sformatf("fill%0d", i));
      modelCommit(v);
    end
    v = mk(1, 1, 17, 32'hFACE, 0, 0, 0, 17, 30, 0, 0);
    runCycle(v, "reset_pulse");
    modelCommit(v);
    for (int i = 0; i < 32; i++) begin
      v = mk(0, 0, 0, 0, 0, 0, 0, AW'(i), AW'(31 - i), 0, 0);
      runCycle(v, $sformatf("cleared%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
